// File: rtl/mp_seq_pkg.sv
// Shared types for the program sequencer: FSM states, fail codes and table entry layout.
package mp_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    FAIL_NONE     = 2'd0,
    FAIL_DRAIN_TO = 2'd1,
    FAIL_ISSUE_TO = 2'd2,
    FAIL_BAD_LEN  = 2'd3
  } seq_fail_e;

  // Entry core_sel is sized for the largest supported core count; the top casts to its width.
  localparam int CORE_SEL_MAX_W = 8;

  typedef struct packed {
    logic [CORE_SEL_MAX_W-1:0] core_sel;
    logic [31:0]               word;
  } prog_entry_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter with synchronous clear and multi-bit increment that sticks at all-ones.
module sat_counter #(
  parameter int W     = 16,
  parameter int INC_W = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [INC_W-1:0] inc,
  output logic [W-1:0]     count
);

  logic [W:0] sum;

  assign sum = {1'b0, count} + (W+1)'(inc);

  always_ff @(posedge clk) begin
    if (clear) count <= '0;
    else       count <= sum[W] ? '1 : sum[W-1:0];
  end

endmodule

// File: rtl/mp_prog_sequencer.sv
// Drives mp_top's instruction-dispatch port from a loadable program table and
// judges completion from load/store activity seen on the shared memory bus.
module mp_prog_sequencer
  import mp_seq_pkg::*;
#(
  parameter int N           = 3,
  parameter int PROG_DEPTH  = 16,
  parameter int TIMEOUT_CYC = 2000,
  parameter int CNT_W       = 16,
  localparam int CORE_SEL_W = (N <= 1) ? 1 : $clog2(N),
  localparam int PTR_W      = $clog2(PROG_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  prog_we,
  input  logic [PTR_W-1:0]      prog_waddr,
  input  logic [CORE_SEL_W-1:0] prog_wcore,
  input  logic [31:0]           prog_wword,
  input  logic [PTR_W:0]        prog_len,
  input  logic [CNT_W-1:0]      exp_ld,
  input  logic [CNT_W-1:0]      exp_st,
  input  logic                  start,
  output logic                  instr_valid,
  output logic [31:0]           instr_word,
  output logic [CORE_SEL_W-1:0] instr_core_sel,
  input  logic                  instr_ready,
  input  logic                  mem_req_valid_dbg,
  input  logic                  mem_req_ready_dbg,
  input  logic                  mem_req_we_dbg,
  input  logic [N-1:0]          core_rf_wen_dbg,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [1:0]            fail_code,
  output logic [CNT_W-1:0]      ld_count,
  output logic [CNT_W-1:0]      st_count,
  output logic [CNT_W-1:0]      reg_wr_count,
  output logic [CNT_W-1:0]      issued_count
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int PC_W  = $clog2(N + 1);

  seq_state_e       state, state_nx;
  seq_fail_e        fail_q;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W:0]   len_q;
  logic [CNT_W-1:0] exp_ld_q, exp_st_q;
  logic [TMR_W-1:0] timer;

  prog_entry_t tbl [PROG_DEPTH];
  prog_entry_t wr_ent, rd_ent;

  logic start_acc, bad_len, xfer, last, timer_exp, drain_ok, bus_xfer;
  logic [PC_W-1:0] rf_pop;

  assign busy        = (state == ISSUE) || (state == DRAIN);
  assign done        = (state == DONE);
  assign instr_valid = (state == ISSUE);
  assign fail_code   = fail_q;

  assign start_acc = start && ((state == IDLE) || (state == DONE));
  assign bad_len   = prog_len > (PTR_W+1)'(PROG_DEPTH);
  assign xfer      = instr_valid && instr_ready;
  assign last      = ({1'b0, ptr} == (len_q - (PTR_W+1)'(1)));
  assign timer_exp = (timer == TMR_W'(TIMEOUT_CYC - 1));
  assign drain_ok  = (ld_count >= exp_ld_q) && (st_count >= exp_st_q);
  assign bus_xfer  = busy && mem_req_valid_dbg && mem_req_ready_dbg;

  // Table read is gated so the dispatch port idles at zero, never at uninitialised contents.
  assign rd_ent         = tbl[ptr];
  assign instr_word     = instr_valid ? rd_ent.word : '0;
  assign instr_core_sel = instr_valid ? CORE_SEL_W'(rd_ent.core_sel) : '0;

  always_comb begin
    wr_ent          = '0;
    wr_ent.core_sel = CORE_SEL_MAX_W'(prog_wcore);
    wr_ent.word     = prog_wword;
  end

  always_ff @(posedge clk) begin
    if (prog_we && !busy) tbl[prog_waddr] <= wr_ent;
  end

  always_comb begin
    rf_pop = '0;
    for (int i = 0; i < N; i++) rf_pop = rf_pop + PC_W'(core_rf_wen_dbg[i]);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          if (bad_len)            state_nx = DONE;
          else if (prog_len == 0) state_nx = DRAIN;
          else                    state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (xfer && last)        state_nx = DRAIN;
        else if (!xfer && timer_exp) state_nx = DONE;
      end
      DRAIN: begin
        if (drain_ok || timer_exp) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      timer    <= '0;
      len_q    <= '0;
      exp_ld_q <= '0;
      exp_st_q <= '0;
      pass     <= 1'b0;
      fail_q   <= FAIL_NONE;
    end else begin
      state <= state_nx;
      if (start_acc) begin
        ptr      <= '0;
        timer    <= '0;
        len_q    <= prog_len;
        exp_ld_q <= exp_ld;
        exp_st_q <= exp_st;
        pass     <= 1'b0;
        fail_q   <= bad_len ? FAIL_BAD_LEN : FAIL_NONE;
      end else begin
        case (state)
          ISSUE: begin
            // A transfer restarts the stall timer; clearing it on the last one also arms DRAIN.
            if (xfer) begin
              ptr   <= ptr + PTR_W'(1);
              timer <= '0;
            end else if (timer_exp) begin
              fail_q <= FAIL_ISSUE_TO;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
          DRAIN: begin
            if (drain_ok)       pass   <= 1'b1;
            else if (timer_exp) fail_q <= FAIL_DRAIN_TO;
            else                timer  <= timer + TMR_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  logic cnt_clr;
  assign cnt_clr = reset || start_acc;

  sat_counter #(.W(CNT_W), .INC_W(1)) u_ld_cnt (
    .clk(clk), .clear(cnt_clr), .inc(bus_xfer && !mem_req_we_dbg), .count(ld_count)
  );

  sat_counter #(.W(CNT_W), .INC_W(1)) u_st_cnt (
    .clk(clk), .clear(cnt_clr), .inc(bus_xfer && mem_req_we_dbg), .count(st_count)
  );

  sat_counter #(.W(CNT_W), .INC_W(PC_W)) u_rw_cnt (
    .clk(clk), .clear(cnt_clr), .inc(busy ? rf_pop : '0), .count(reg_wr_count)
  );

  sat_counter #(.W(CNT_W), .INC_W(1)) u_iss_cnt (
    .clk(clk), .clear(cnt_clr), .inc(xfer), .count(issued_count)
  );

endmodule

// File: tb/tb_mp_prog_sequencer.sv
// Randomized self-checking bench: a table model plus a simple bus-activity model stand in for mp_top.
module tb_mp_prog_sequencer;

  localparam int N     = 3;
  localparam int DEPTH = 16;
  localparam int TO    = 100;
  localparam int CNT_W = 16;
  localparam int CSW   = 2;
  localparam int PTR_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             prog_we;
  logic [PTR_W-1:0] prog_waddr;
  logic [CSW-1:0]   prog_wcore;
  logic [31:0]      prog_wword;
  logic [PTR_W:0]   prog_len;
  logic [CNT_W-1:0] exp_ld, exp_st;
  logic             start;
  logic             instr_valid;
  logic [31:0]      instr_word;
  logic [CSW-1:0]   instr_core_sel;
  logic             instr_ready;
  logic             mem_req_valid_dbg, mem_req_ready_dbg, mem_req_we_dbg;
  logic [N-1:0]     core_rf_wen_dbg;
  logic             busy, done, pass;
  logic [1:0]       fail_code;
  logic [CNT_W-1:0] ld_count, st_count, reg_wr_count, issued_count;

  mp_prog_sequencer #(.N(N), .PROG_DEPTH(DEPTH), .TIMEOUT_CYC(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_waddr(prog_waddr),
    .prog_wcore(prog_wcore), .prog_wword(prog_wword), .prog_len(prog_len),
    .exp_ld(exp_ld), .exp_st(exp_st), .start(start), .instr_valid(instr_valid),
    .instr_word(instr_word), .instr_core_sel(instr_core_sel), .instr_ready(instr_ready),
    .mem_req_valid_dbg(mem_req_valid_dbg), .mem_req_ready_dbg(mem_req_ready_dbg),
    .mem_req_we_dbg(mem_req_we_dbg), .core_rf_wen_dbg(core_rf_wen_dbg),
    .busy(busy), .done(done), .pass(pass), .fail_code(fail_code),
    .ld_count(ld_count), .st_count(st_count), .reg_wr_count(reg_wr_count),
    .issued_count(issued_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Program model and expected bus activity for the current run.
  logic [31:0] tbl_w [DEPTH];
  int          tbl_c [DEPTH];
  int          m_ld, m_st, m_rw, m_iss;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load(input int a, input int c, input logic [31:0] w);
    prog_we = 1'b1; prog_waddr = PTR_W'(a); prog_wcore = CSW'(c); prog_wword = w;
    tbl_w[a] = w; tbl_c[a] = c;
    tick();
    prog_we = 1'b0;
  endtask

  // rmode: 0 ready low, 1 ready high, 2 random. emode: 0 quiet, 1 opcode-driven bus, 2 random bus + busy noise.
  task automatic run(input int len, input int el, input int es, input int rmode,
                     input int emode, input int budget, output int cyc);
    int nx;
    bit pend;
    logic [31:0] pw;
    int pc;
    bit mv, mr;
    nx = 0; pend = 0; pw = '0; pc = 0;
    m_ld = 0; m_st = 0; m_rw = 0;
    prog_len = (PTR_W+1)'(len); exp_ld = CNT_W'(el); exp_st = CNT_W'(es);
    start = 1'b1;
    tick();
    start = 1'b0; prog_we = 1'b0;
    cyc = 0;
    while (!done && cyc < budget) begin
      start = 1'b0; prog_we = 1'b0;
      instr_ready = (rmode == 0) ? 1'b0 : (rmode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
      mem_req_valid_dbg = 1'b0; mem_req_ready_dbg = 1'b0; mem_req_we_dbg = 1'b0;
      core_rf_wen_dbg = '0;
      if (emode == 1 && pend) begin
        case (pw[31:28])
          4'h1: begin
            mem_req_valid_dbg = 1'b1; mem_req_ready_dbg = 1'b1;
            core_rf_wen_dbg[pc] = 1'b1; m_ld++; m_rw++;
          end
          4'h2: begin
            mem_req_valid_dbg = 1'b1; mem_req_ready_dbg = 1'b1; mem_req_we_dbg = 1'b1; m_st++;
          end
          4'h3: begin core_rf_wen_dbg[pc] = 1'b1; m_rw++; end
          default: ;
        endcase
      end else if (emode == 2 && nx < len) begin
        mv = 1'($urandom_range(0, 1)); mr = 1'($urandom_range(0, 1));
        mem_req_valid_dbg = mv; mem_req_ready_dbg = mr;
        mem_req_we_dbg = 1'($urandom_range(0, 1));
        core_rf_wen_dbg = N'($urandom_range(0, 7));
        if (mv && mr) begin
          if (mem_req_we_dbg) m_st++; else m_ld++;
        end
        m_rw += $countones(core_rf_wen_dbg);
        start = ($urandom_range(0, 7) == 0);
        prog_we = ($urandom_range(0, 5) == 0);
        prog_waddr = PTR_W'($urandom); prog_wcore = CSW'($urandom_range(0, 2));
        prog_wword = $urandom;
      end
      pend = 0;
      if (instr_valid) begin
        if (nx < len) begin
          chk($sformatf("word[%0d]", nx), 64'(instr_word), 64'(tbl_w[nx]));
          chk($sformatf("core[%0d]", nx), 64'(instr_core_sel), 64'(tbl_c[nx]));
          if (instr_ready) begin pend = 1; pw = tbl_w[nx]; pc = tbl_c[nx]; nx++; end
        end else begin
          chk("valid_after_last", 64'(instr_valid), 64'd0);
        end
      end
      tick();
      cyc++;
    end
    start = 1'b0; prog_we = 1'b0; instr_ready = 1'b0;
    mem_req_valid_dbg = 1'b0; mem_req_ready_dbg = 1'b0; mem_req_we_dbg = 1'b0;
    core_rf_wen_dbg = '0;
    m_iss = nx;
  endtask

  int cyc;

  initial begin
    reset = 1'b1; prog_we = 1'b0; prog_waddr = '0; prog_wcore = '0; prog_wword = '0;
    prog_len = '0; exp_ld = '0; exp_st = '0; start = 1'b0; instr_ready = 1'b0;
    mem_req_valid_dbg = 1'b0; mem_req_ready_dbg = 1'b0; mem_req_we_dbg = 1'b0;
    core_rf_wen_dbg = '0;
    for (int i = 0; i < DEPTH; i++) begin tbl_w[i] = '0; tbl_c[i] = 0; end
    tick(); tick();
    reset = 1'b0;
    tick();

    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_pass", 64'(pass), 0);
    chk("rst_fail", 64'(fail_code), 0);
    chk("rst_valid", 64'(instr_valid), 0);
    chk("rst_word", 64'(instr_word), 0);
    chk("rst_counts", 64'({ld_count, st_count, reg_wr_count, issued_count}), 0);

    // Smoke program on core0: opcode nibble 1=LDR 2=STR 3=ADD 0=NOP.
    load(0, 0, 32'h1100_0000);
    load(1, 0, 32'h1200_0001);
    load(2, 0, 32'h3312_0000);
    load(3, 0, 32'h2300_0010);
    load(4, 0, 32'h1400_0010);
    load(5, 0, 32'h0000_0000);
    run(6, 3, 1, 1, 1, 50, cyc);
    chk("smoke_done", 64'(done), 1);
    chk("smoke_pass", 64'(pass), 1);
    chk("smoke_fail", 64'(fail_code), 0);
    chk("smoke_ld", 64'(ld_count), 64'(m_ld));
    chk("smoke_st", 64'(st_count), 64'(m_st));
    chk("smoke_rw", 64'(reg_wr_count), 64'(m_rw));
    chk("smoke_iss", 64'(issued_count), 64'd6);
    chk("smoke_model_ld", 64'(m_ld), 64'd3);

    run(6, 3, 5, 1, 1, 3 * TO, cyc);
    chk("drto_done", 64'(done), 1);
    chk("drto_fail", 64'(fail_code), 1);
    chk("drto_pass", 64'(pass), 0);
    chk("drto_st", 64'(st_count), 64'd1);
    chk("drto_cyc", 64'(cyc), 64'(6 + TO));

    run(6, 0, 0, 0, 0, TO + 50, cyc);
    chk("isto_cyc", 64'(cyc), 64'(TO));
    chk("isto_fail", 64'(fail_code), 2);
    chk("isto_iss", 64'(issued_count), 0);
    chk("isto_valid", 64'(instr_valid), 0);

    run(0, 0, 0, 1, 0, 20, cyc);
    chk("len0_cyc", 64'(cyc), 1);
    chk("len0_pass", 64'(pass), 1);
    chk("len0_iss", 64'(issued_count), 0);

    for (int i = 0; i < DEPTH; i++) load(i, $urandom_range(0, 2), $urandom);
    run(16, 0, 0, 2, 2, 500, cyc);
    chk("rand_done", 64'(done), 1);
    chk("rand_pass", 64'(pass), 1);
    chk("rand_iss", 64'(issued_count), 64'd16);
    chk("rand_model_iss", 64'(m_iss), 64'd16);
    chk("rand_ld", 64'(ld_count), 64'(m_ld));
    chk("rand_st", 64'(st_count), 64'(m_st));
    chk("rand_rw", 64'(reg_wr_count), 64'(m_rw));

    // Reset part-way through ISSUE.
    run(16, 0, 0, 1, 2, 4, cyc);
    chk("mid_busy", 64'(busy), 1);
    reset = 1'b1;
    tick();
    chk("mrst_busy", 64'(busy), 0);
    chk("mrst_valid", 64'(instr_valid), 0);
    chk("mrst_done", 64'(done), 0);
    chk("mrst_counts", 64'({ld_count, st_count, reg_wr_count, issued_count}), 0);
    reset = 1'b0;
    tick();

    // Write and start together in IDLE: the run must see the new entry.
    prog_we = 1'b1; prog_waddr = '0; prog_wcore = 2'd2; prog_wword = 32'hCAFE_0001;
    tbl_w[0] = 32'hCAFE_0001; tbl_c[0] = 2;
    run(1, 0, 0, 1, 0, 20, cyc);
    chk("wrst_iss", 64'(issued_count), 1);
    chk("wrst_pass", 64'(pass), 1);

    run(17, 0, 0, 1, 0, 10, cyc);
    chk("badlen_cyc", 64'(cyc), 0);
    chk("badlen_done", 64'(done), 1);
    chk("badlen_fail", 64'(fail_code), 3);
    chk("badlen_pass", 64'(pass), 0);
    chk("badlen_busy", 64'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
